// File: rtl/aes_result_scanner.sv
// Captures a 128-bit AES result and presents its bytes MSB-first on byteOut,
// holding each byte for DWELL cycles so the display path can show the whole block.
module aes_result_scanner #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned LOOP  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] dataIn,
    input  logic         hold,
    input  logic         abort,
    output logic [7:0]   byteOut,
    output logic [3:0]   byteIndex,
    output logic         busy,
    output logic         done
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e        state_q, state_d;
    logic [127:0]  data_q, data_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    idx_inc;
    logic [127:0]  next_sh;

    // Shifting the captured block left puts the following byte in the top lane.
    assign idx_inc = idx_q + 4'd1;
    assign next_sh = data_q << {idx_inc, 3'b000};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dwell_d = dwell_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = StIdle;
            dwell_d = '0;
            idx_d   = 4'd0;
            byte_d  = 8'h00;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        state_d = StScan;
                        data_d  = dataIn;
                        dwell_d = '0;
                        idx_d   = 4'd0;
                        byte_d  = dataIn[127:120];
                        busy_d  = 1'b1;
                    end
                end
                StScan: begin
                    if (!hold) begin
                        if (dwell_q != DwellLast) begin
                            dwell_d = dwell_q + DW'(1);
                        end else if (idx_q != 4'd15) begin
                            dwell_d = '0;
                            idx_d   = idx_inc;
                            byte_d  = next_sh[127:120];
                        end else if (LOOP != 0) begin
                            dwell_d = '0;
                            idx_d   = 4'd0;
                            byte_d  = data_q[127:120];
                        end else begin
                            state_d = StIdle;
                            dwell_d = '0;
                            idx_d   = 4'd0;
                            byte_d  = 8'h00;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            dwell_q <= '0;
            idx_q   <= 4'd0;
            byte_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign byteOut   = byte_q;
    assign byteIndex = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
